// File: rtl/uart_param_core_if.sv
// Host-side handshake bundle for uart_param_core: TX word offer plus RX FIFO head/status.
interface uart_param_core_if #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned RX_FIFO_DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

  logic                 i_TX_Valid;
  logic                 o_TX_Ready;
  logic [DATA_BITS-1:0] i_TX_Data;
  logic                 o_TX_Busy;
  logic                 o_RX_Valid;
  logic                 i_RX_Ready;
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_RX_Parity_Err;
  logic                 o_RX_Frame_Err;
  logic                 o_RX_Overrun;
  logic                 i_Overrun_Clr;
  logic [CNT_W-1:0]     o_RX_Count;

  modport master (
    output i_TX_Valid, i_TX_Data, i_RX_Ready, i_Overrun_Clr,
    input  o_TX_Ready, o_TX_Busy, o_RX_Valid, o_RX_Data,
           o_RX_Parity_Err, o_RX_Frame_Err, o_RX_Overrun, o_RX_Count
  );

  modport slave (
    input  i_TX_Valid, i_TX_Data, i_RX_Ready, i_Overrun_Clr,
    output o_TX_Ready, o_TX_Busy, o_RX_Valid, o_RX_Data,
           o_RX_Parity_Err, o_RX_Frame_Err, o_RX_Overrun, o_RX_Count
  );
endinterface

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: TX serialiser, oversampled RX with parity/frame checks,
// and a first-word-fall-through RX FIFO with sticky overrun.
module uart_param_core #(
  parameter int unsigned CLK_HZ        = 80000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  output logic              o_TX,
  input  logic              i_RX,
  uart_param_core_if.slave  bus
);
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BIT_CW = $clog2(STOP_BITS * DIV + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS);
  localparam int unsigned AW     = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned WORD_W = DATA_BITS + 2;

  localparam logic [BIT_CW-1:0] DIV_M1   = BIT_CW'(DIV - 1);
  localparam logic [BIT_CW-1:0] HALF_M1  = BIT_CW'(DIV / 2 - 1);
  localparam logic [BIT_CW-1:0] STOP_M1  = BIT_CW'(STOP_BITS * DIV - 1);
  localparam logic [BIT_CW-1:0] CNT_ONE  = BIT_CW'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [AW:0]       PTR_ONE  = (AW + 1)'(1);

  // Even parity is the XOR of the data bits; odd is its complement.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------- TX ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state;
  logic [BIT_CW-1:0]    tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_ready_q;
  logic                 tx_busy_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      o_TX       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          o_TX       <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_busy_q  <= 1'b0;
          if (bus.i_TX_Valid && tx_ready_q) begin
            tx_shift   <= bus.i_TX_Data;
            tx_par     <= calc_parity(bus.i_TX_Data);
            tx_cnt     <= '0;
            tx_state   <= TX_START;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            o_TX       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
            o_TX     <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_IDX) begin
              if (PARITY != 0) begin
                tx_state <= TX_PARITY;
                o_TX     <= tx_par;
              end else begin
                tx_state <= TX_STOP;
                o_TX     <= 1'b1;
              end
            end else begin
              tx_idx   <= tx_idx + IDX_ONE;
              tx_shift <= tx_shift >> 1;
              o_TX     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_state <= TX_STOP;
            o_TX     <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == STOP_M1) begin
            tx_cnt     <= '0;
            tx_state   <= TX_IDLE;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.o_TX_Ready = tx_ready_q;
  assign bus.o_TX_Busy  = tx_busy_q;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  rx_state_t            rx_state;
  logic [BIT_CW-1:0]    rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_err;
  logic                 rx_wr_c;
  logic [WORD_W-1:0]    rx_word_c;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_err <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= HALF_M1;
            rx_state <= RX_START_CHK;
          end
        end
        RX_START_CHK: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else if (rx_sync) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt     <= DIV_M1;
            rx_idx     <= '0;
            rx_par_err <= 1'b0;
            rx_state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_cnt   <= DIV_M1;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == LAST_IDX) begin
              rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + IDX_ONE;
            end
          end
        end
        RX_PARITY: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_cnt     <= DIV_M1;
            rx_par_err <= (rx_sync != calc_parity(rx_shift));
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Only the first stop bit is inspected; later ones overlap the next idle.
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_wr_c   = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_word_c = {~rx_sync, rx_par_err, rx_shift};

  // ---------------- RX FIFO ----------------
  logic [WORD_W-1:0] mem [RX_FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count_q;
  logic              overrun_q;
  logic              empty_c;
  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic [WORD_W-1:0] head_c;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c   = bus.i_RX_Ready && !empty_c;
  assign push_c  = rx_wr_c && (!full_c || pop_c);
  assign drop_c  = rx_wr_c && full_c && !pop_c;

  always_ff @(posedge i_Clock) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= rx_word_c;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_c)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
      // A new drop outranks a simultaneous clear.
      if (drop_c)                 overrun_q <= 1'b1;
      else if (bus.i_Overrun_Clr) overrun_q <= 1'b0;
    end
  end

  assign head_c              = mem[rd_ptr[AW-1:0]];
  assign bus.o_RX_Valid      = !empty_c;
  assign bus.o_RX_Data       = empty_c ? '0 : head_c[DATA_BITS-1:0];
  assign bus.o_RX_Parity_Err = empty_c ? 1'b0 : head_c[DATA_BITS];
  assign bus.o_RX_Frame_Err  = empty_c ? 1'b0 : head_c[DATA_BITS+1];
  assign bus.o_RX_Overrun    = overrun_q;
  assign bus.o_RX_Count      = count_q;
endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: DUT A (even parity, depth 16, TX/RX/loopback/reset),
// DUT B (odd parity, two stop bits, depth 4, glitch/parity/overrun).
module tb_uart_param_core;
  localparam int unsigned DIV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic tx_a, tx_b, rx_a;
  logic rx_drv_a = 1'b1;
  logic rx_drv_b = 1'b1;
  logic loop_a   = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  uart_param_core_if #(.DATA_BITS(8), .RX_FIFO_DEPTH(16)) bus_a ();
  uart_param_core_if #(.DATA_BITS(8), .RX_FIFO_DEPTH(4))  bus_b ();

  assign rx_a = loop_a ? tx_a : rx_drv_a;

  uart_param_core #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .RX_FIFO_DEPTH(16)) dut_a (
    .i_Clock(clk), .i_Reset(rst_a), .o_TX(tx_a), .i_RX(rx_a), .bus(bus_a.slave));

  uart_param_core #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dut_b (
    .i_Clock(clk), .i_Reset(rst_b), .o_TX(tx_b), .i_RX(rx_drv_b), .bus(bus_b.slave));

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_drv_a = v; else rx_drv_b = v;
  endtask

  task automatic set_pop(input int sel, input logic v);
    if (sel == 0) bus_a.i_RX_Ready = v; else bus_b.i_RX_Ready = v;
  endtask

  // Serial frame onto an RX line; pop_n >= 0 pulses i_RX_Ready on that cycle of the frame.
  task automatic drive_frame(input int sel, input logic [7:0] data, input bit odd,
                             input bit flip, input logic stop_val, input int pop_n);
    logic [10:0] vec;
    logic        p;
    p = ^data;
    if (odd)  p = ~p;
    if (flip) p = ~p;
    vec = {stop_val, p, data, 1'b0};
    for (int n = 0; n < 11 * DIV; n++) begin
      set_line(sel, vec[n / DIV]);
      if (pop_n >= 0) set_pop(sel, n == pop_n);
      @(negedge clk);
    end
    set_line(sel, 1'b1);
    set_pop(sel, 1'b0);
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic pop_word(input int sel, output logic v, output logic [7:0] d,
                          output logic pe, output logic fe);
    if (sel == 0) begin
      v = bus_a.o_RX_Valid; d = bus_a.o_RX_Data;
      pe = bus_a.o_RX_Parity_Err; fe = bus_a.o_RX_Frame_Err;
    end else begin
      v = bus_b.o_RX_Valid; d = bus_b.o_RX_Data;
      pe = bus_b.o_RX_Parity_Err; fe = bus_b.o_RX_Frame_Err;
    end
    set_pop(sel, 1'b1);
    @(negedge clk);
    set_pop(sel, 1'b0);
  endtask

  task automatic wait_tx_ready(input string name);
    int t = 0;
    while (bus_a.o_TX_Ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (bus_a.o_TX_Ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: o_TX_Ready still %b after 1000 clocks, expected 1", name, bus_a.o_TX_Ready);
    end
  endtask

  task automatic send_tx(input logic [7:0] data);
    wait_tx_ready("send_tx_ready");
    bus_a.i_TX_Valid = 1'b1;
    bus_a.i_TX_Data  = data;
    @(negedge clk);
    bus_a.i_TX_Valid = 1'b0;
  endtask

  task automatic test_reset();
    bus_a.i_TX_Valid = 1'b0; bus_a.i_TX_Data = '0; bus_a.i_RX_Ready = 1'b0; bus_a.i_Overrun_Clr = 1'b0;
    bus_b.i_TX_Valid = 1'b0; bus_b.i_TX_Data = '0; bus_b.i_RX_Ready = 1'b0; bus_b.i_Overrun_Clr = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_a, bus_a.o_TX_Busy, bus_a.o_TX_Ready} !== 3'b100) begin
      errors++; $display("FAIL reset_tx: {tx,busy,ready}=%b expected 100",
                         {tx_a, bus_a.o_TX_Busy, bus_a.o_TX_Ready});
    end
    checks++;
    if ({bus_a.o_RX_Valid, bus_a.o_RX_Overrun, bus_a.o_RX_Parity_Err, bus_a.o_RX_Frame_Err} !== 4'b0000) begin
      errors++; $display("FAIL reset_rx_flags: {valid,ovr,pe,fe}=%b expected 0000",
                         {bus_a.o_RX_Valid, bus_a.o_RX_Overrun, bus_a.o_RX_Parity_Err, bus_a.o_RX_Frame_Err});
    end
    checks++;
    if ({bus_a.o_RX_Count, bus_a.o_RX_Data} !== 13'h0) begin
      errors++; $display("FAIL reset_rx_data: count=%0d data=%0h expected 0 0",
                         bus_a.o_RX_Count, bus_a.o_RX_Data);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.o_TX_Ready, bus_a.o_TX_Busy, tx_a} !== 3'b101) begin
      errors++; $display("FAIL reset_release: {ready,busy,tx}=%b expected 101",
                         {bus_a.o_TX_Ready, bus_a.o_TX_Busy, tx_a});
    end
    checks++;
    if (bus_b.o_RX_Count !== 3'd0) begin
      errors++; $display("FAIL reset_count_b: count=%0d expected 0", bus_b.o_RX_Count);
    end
  endtask

  // vec holds the line level per bit period, index 0 = start bit.
  task automatic test_tx_frame(input logic [7:0] data, input logic [10:0] vec);
    wait_tx_ready("tx_frame_ready");
    bus_a.i_TX_Valid = 1'b1;
    bus_a.i_TX_Data  = data;
    @(negedge clk);
    bus_a.i_TX_Valid = 1'b0;
    for (int k = 0; k < 11 * DIV; k++) begin
      checks++;
      if (tx_a !== vec[k / DIV]) begin
        errors++; $display("FAIL tx_bit[%0d]: o_TX=%b expected %b", k, tx_a, vec[k / DIV]);
      end
      if (k == 0 || k == 11 * DIV - 1) begin
        checks++;
        if ({bus_a.o_TX_Busy, bus_a.o_TX_Ready} !== 2'b10) begin
          errors++; $display("FAIL tx_busy[%0d]: {busy,ready}=%b expected 10", k,
                             {bus_a.o_TX_Busy, bus_a.o_TX_Ready});
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({bus_a.o_TX_Ready, bus_a.o_TX_Busy, tx_a} !== 3'b101) begin
      errors++; $display("FAIL tx_done_176: {ready,busy,tx}=%b expected 101",
                         {bus_a.o_TX_Ready, bus_a.o_TX_Busy, tx_a});
    end
  endtask

  task automatic test_loopback();
    logic       v, pe, fe;
    logic [7:0] d;
    logic [7:0] exp_d [3] = '{8'h00, 8'hFF, 8'h3C};
    loop_a = 1'b1;
    for (int i = 0; i < 3; i++) send_tx(exp_d[i]);
    wait_tx_ready("loop_drain");
    repeat (20) @(negedge clk);
    checks++;
    if (bus_a.o_RX_Count !== 5'd3) begin
      errors++; $display("FAIL loop_count: count=%0d expected 3", bus_a.o_RX_Count);
    end
    for (int i = 0; i < 3; i++) begin
      pop_word(0, v, d, pe, fe);
      checks++;
      if ({v, d, pe, fe} !== {1'b1, exp_d[i], 2'b00}) begin
        errors++; $display("FAIL loop_word[%0d]: {v,data,pe,fe}=%b_%h_%b%b expected 1_%h_00",
                           i, v, d, pe, fe, exp_d[i]);
      end
    end
    checks++;
    if ({bus_a.o_RX_Valid, bus_a.o_RX_Count} !== 6'd0) begin
      errors++; $display("FAIL loop_empty: valid=%b count=%0d expected 0 0",
                         bus_a.o_RX_Valid, bus_a.o_RX_Count);
    end
    loop_a = 1'b0;
  endtask

  task automatic test_frame_error();
    logic       v, pe, fe;
    logic [7:0] d;
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    drive_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
    checks++;
    if (bus_a.o_RX_Count !== 5'd2) begin
      errors++; $display("FAIL ferr_count: count=%0d expected 2", bus_a.o_RX_Count);
    end
    pop_word(0, v, d, pe, fe);
    checks++;
    if ({v, d, pe, fe} !== {1'b1, 8'h55, 2'b01}) begin
      errors++; $display("FAIL ferr_word: {v,data,pe,fe}=%b_%h_%b%b expected 1_55_01", v, d, pe, fe);
    end
    pop_word(0, v, d, pe, fe);
    checks++;
    if ({v, d, pe, fe} !== {1'b1, 8'h12, 2'b00}) begin
      errors++; $display("FAIL ferr_next: {v,data,pe,fe}=%b_%h_%b%b expected 1_12_00", v, d, pe, fe);
    end
  endtask

  task automatic test_glitch_parity();
    logic       v, pe, fe;
    logic [7:0] d;
    rx_drv_b = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv_b = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ({bus_b.o_RX_Valid, bus_b.o_RX_Count} !== 4'd0) begin
      errors++; $display("FAIL glitch_nowrite: valid=%b count=%0d expected 0 0",
                         bus_b.o_RX_Valid, bus_b.o_RX_Count);
    end
    drive_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1);
    drive_frame(1, 8'h01, 1'b1, 1'b0, 1'b1, -1);
    checks++;
    if (bus_b.o_RX_Count !== 3'd2) begin
      errors++; $display("FAIL par_count: count=%0d expected 2", bus_b.o_RX_Count);
    end
    pop_word(1, v, d, pe, fe);
    checks++;
    if ({v, d, pe, fe} !== {1'b1, 8'h3C, 2'b10}) begin
      errors++; $display("FAIL par_err_word: {v,data,pe,fe}=%b_%h_%b%b expected 1_3c_10", v, d, pe, fe);
    end
    pop_word(1, v, d, pe, fe);
    checks++;
    if ({v, d, pe, fe} !== {1'b1, 8'h01, 2'b00}) begin
      errors++; $display("FAIL par_ok_word: {v,data,pe,fe}=%b_%h_%b%b expected 1_01_00", v, d, pe, fe);
    end
  endtask

  task automatic test_overrun();
    logic       v, pe, fe;
    logic [7:0] d;
    logic [7:0] in_d  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 5; i++) drive_frame(1, in_d[i], 1'b1, 1'b0, 1'b1, -1);
    checks++;
    if ({bus_b.o_RX_Count, bus_b.o_RX_Overrun} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL ovr_full: count=%0d overrun=%b expected 4 1",
                         bus_b.o_RX_Count, bus_b.o_RX_Overrun);
    end
    checks++;
    if ({bus_b.o_RX_Valid, bus_b.o_RX_Data} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL ovr_head: valid=%b data=%h expected 1 11",
                         bus_b.o_RX_Valid, bus_b.o_RX_Data);
    end
    bus_b.i_Overrun_Clr = 1'b1;
    @(negedge clk);
    bus_b.i_Overrun_Clr = 1'b0;
    checks++;
    if (bus_b.o_RX_Overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: overrun=%b expected 0", bus_b.o_RX_Overrun);
    end
    // Stop bit starts at cycle 160; the write lands 11 clocks in, seen by cycle 170's pop.
    drive_frame(1, 8'h66, 1'b1, 1'b0, 1'b1, 10 * DIV + 10);
    checks++;
    if ({bus_b.o_RX_Count, bus_b.o_RX_Overrun} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL ovr_pop_write: count=%0d overrun=%b expected 4 0",
                         bus_b.o_RX_Count, bus_b.o_RX_Overrun);
    end
    for (int i = 0; i < 4; i++) begin
      pop_word(1, v, d, pe, fe);
      checks++;
      if ({v, d, pe, fe} !== {1'b1, exp_d[i], 2'b00}) begin
        errors++; $display("FAIL ovr_word[%0d]: {v,data,pe,fe}=%b_%h_%b%b expected 1_%h_00",
                           i, v, d, pe, fe, exp_d[i]);
      end
    end
    checks++;
    if ({bus_b.o_RX_Valid, bus_b.o_RX_Count} !== 4'd0) begin
      errors++; $display("FAIL ovr_empty: valid=%b count=%0d expected 0 0",
                         bus_b.o_RX_Valid, bus_b.o_RX_Count);
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] rx_vec = {1'b1, 1'b0, 8'hC3, 1'b0};
    // RX frame starts 16 clocks before the TX accept; cycle 86 is inside RX data bit 4 and TX data bit 3.
    for (int n = 0; n < 86; n++) begin
      rx_drv_a = rx_vec[n / DIV];
      if (n == 16) begin bus_a.i_TX_Valid = 1'b1; bus_a.i_TX_Data = 8'h5A; end
      if (n == 17) bus_a.i_TX_Valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({bus_a.o_TX_Busy, bus_a.o_RX_Valid} !== 2'b10) begin
      errors++; $display("FAIL mid_pre: {busy,rx_valid}=%b expected 10", {bus_a.o_TX_Busy, bus_a.o_RX_Valid});
    end
    rst_a    = 1'b1;
    rx_drv_a = 1'b1;
    #1;
    checks++;
    if ({tx_a, bus_a.o_TX_Busy, bus_a.o_TX_Ready, bus_a.o_RX_Count} !== {3'b100, 5'd0}) begin
      errors++; $display("FAIL mid_reset: {tx,busy,ready}=%b count=%0d expected 100 0",
                         {tx_a, bus_a.o_TX_Busy, bus_a.o_TX_Ready}, bus_a.o_RX_Count);
    end
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    checks++;
    if ({bus_a.o_RX_Valid, bus_a.o_RX_Count} !== 6'd0) begin
      errors++; $display("FAIL mid_nowrite: valid=%b count=%0d expected 0 0",
                         bus_a.o_RX_Valid, bus_a.o_RX_Count);
    end
    test_tx_frame(8'h5A, 11'b1_0_01011010_0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_frame(8'hA5, 11'b1_0_10100101_0);
    test_loopback();
    test_frame_error();
    test_glitch_parity();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised full-duplex UART core, single clock domain (i_Clock). Configurable baud divisor, data width, parity and stop bits. TX accepts words over a valid/ready handshake. RX oversamples with a synchroniser and start-bit validation, checks parity and stop bits, and buffers words plus error flags in an internal first-word-fall-through FIFO with overrun detection. Sits between the host-side fabric logic and the board TX/RX pins.

Parameters:
CLK_HZ, 80000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer truncation), bit period = DIV clocks; DIV must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
RX_FIFO_DEPTH, 16, RX FIFO entries, power of 2, >= 2

Ports:
i_Clock  in  1  system clock, rising edge
i_Reset  in  1  asynchronous, active-high reset
i_TX_Valid  in  1  TX word offered
o_TX_Ready  out  1  TX idle, word accepted when i_TX_Valid & o_TX_Ready
i_TX_Data  in  DATA_BITS  TX word, sampled at accept
o_TX  out  1  serial TX line, idle high
o_TX_Busy  out  1  frame in progress
i_RX  in  1  serial RX line (asynchronous)
o_RX_Valid  out  1  RX FIFO not empty
i_RX_Ready  in  1  pop head word when o_RX_Valid & i_RX_Ready
o_RX_Data  out  DATA_BITS  head word data
o_RX_Parity_Err  out  1  head word parity mismatch (0 when PARITY=0)
o_RX_Frame_Err  out  1  head word had a stop bit sampled low
o_RX_Overrun  out  1  sticky: a received word was dropped
i_Overrun_Clr  in  1  clears o_RX_Overrun
o_RX_Count  out  clog2(RX_FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
Reset (async): o_TX=1, o_TX_Busy=0, o_TX_Ready=0 while asserted and 1 from the first clock after release; FIFO emptied; o_RX_Valid=0, o_RX_Count=0, o_RX_Overrun=0; o_RX_Data and error flags = 0; both FSMs return to IDLE. Reset mid-frame aborts the frame with no partial FIFO write.
TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- On accept, latch i_TX_Data and restart the bit counter at 0. o_TX goes low on the next clock.
- Each state holds exactly DIV clocks. Data is sent LSB first.
- Parity bit: even = XOR of data; odd = ~XOR.
- STOP drives 1 for STOP_BITS*DIV clocks.
- o_TX_Ready = (state==IDLE). o_TX_Busy = ~o_TX_Ready.
- Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV clocks, accept to ready. Back-to-back words produce no idle gap beyond 1 clock.
RX synchroniser: two flops on i_RX; all RX logic uses the synchronised signal.
RX FSM: IDLE -> START_CHK -> DATA -> PARITY (optional) -> STOP -> IDLE.
- IDLE: a synchronised falling edge (1->0) enters START_CHK with counter = DIV/2-1.
- START_CHK: at counter 0 sample the line. If high, it is a false start: return to IDLE, no write. If low, go to DATA with counter = DIV-1.
- Every later sample is taken when the counter reaches 0, then the counter reloads DIV-1. Data bits are assembled LSB first.
- Parity error = received parity bit != computed parity.
- Frame error = any stop bit sampled 0. Only the first stop bit is checked when STOP_BITS=2; the FSM returns to IDLE right after sampling it.
- The FIFO write happens on the cycle the first stop bit is sampled. The word is {frame_err, parity_err, data}.
- A frame with a frame error is still written. The FSM re-arms in IDLE and requires a high line before the next falling edge.
RX FIFO:
- First-word-fall-through: outputs show the head entry combinationally from the registered read pointer.
- Pointers have clog2(DEPTH)+1 bits with wrap-around. full = MSB differs and LSBs are equal.
- Pop with o_RX_Valid=0 is ignored.
- Write while full, with no pop in the same cycle: word dropped, o_RX_Overrun set on the next clock, FIFO contents unchanged.
- Write and pop in the same cycle while full: both happen, no overrun, count unchanged.
- Write and pop in the same cycle otherwise: count unchanged.
- i_Overrun_Clr in the same cycle as a new overrun: set wins.

Test Plan:
Use CLK_HZ=1600000 and BAUD=100000 (DIV=16) throughout; the first three scenarios also use DATA_BITS=8, PARITY=2, STOP_BITS=1.
TX 0xA5 -> o_TX low 16 clks, then 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 16 clks; o_TX_Ready high again 176 clks after accept.
TX looped to RX, send 0x00, 0xFF, 0x3C -> three FIFO entries with matching data, all error flags 0, o_RX_Count=3.
RX frame with stop bit driven 0, data 0x55 -> entry 0x55 with o_RX_Frame_Err=1; following good frame 0x12 -> flags 0.
RX 6-clock low glitch on idle line -> no FIFO write, FSM back in IDLE; PARITY=1 with parity bit flipped -> o_RX_Parity_Err=1.
RX_FIFO_DEPTH=4, receive 5 frames with no pops -> count=4, first 4 words intact, o_RX_Overrun=1; pop during 5th write on full -> no overrun, count stays 4; i_Overrun_Clr clears the flag.
Assert i_Reset mid-way through TX data bit 3 and RX data bit 4 -> o_TX=1 immediately, no FIFO write, o_RX_Count=0, next TX frame after release is correct.
